// File: rtl/draw_board.sv
// Battleship board renderer: 10x10 grid of 32x32 cells overlaid on the VGA stream.
// Optional grid lines are enabled with `define DRAW_BOARD_GRID_EN.
module draw_board #(
   parameter int unsigned X0         = 64,
   parameter int unsigned Y0         = 48,
   parameter logic [11:0] SHIP_COLOR = 12'h888,
   parameter logic [11:0] HIT_COLOR  = 12'hF00,
   parameter logic [11:0] MISS_COLOR = 12'h00F,
   parameter logic [11:0] GRID_COLOR = 12'hFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   input  logic        cell_we,
   input  logic [3:0]  cell_x,
   input  logic [3:0]  cell_y,
   input  logic [1:0]  cell_state,
   input  logic        board_clr,
   output logic        busy,
   output logic [6:0]  rom_addr,
   input  logic [31:0] ship_line_pixels_in,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);

   localparam int unsigned NCELL = 100;
   localparam int unsigned NSIDE = 10;
   localparam int unsigned BSIZE = 320;
   localparam int unsigned TW    = 26;

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t      state, state_nxt;
   logic [6:0]  clr_idx;
   logic        clr_we_c, wr_en_c, busy_nxt_c;
   logic [1:0]  cells [NCELL];

   // Clear FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (board_clr) state_nxt = CLEAR;
         CLEAR:   if (clr_idx == 7'(NCELL - 1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A clear request in IDLE takes precedence over a simultaneous cell write
   always_comb begin
      clr_we_c   = 1'b0;
      wr_en_c    = 1'b0;
      busy_nxt_c = 1'b0;
      if (state == CLEAR) clr_we_c = 1'b1;
      if (state == IDLE && !board_clr && cell_we &&
          cell_x < 4'(NSIDE) && cell_y < 4'(NSIDE)) wr_en_c = 1'b1;
      if (state_nxt == CLEAR) busy_nxt_c = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_idx <= '0;
         busy    <= 1'b0;
      end else begin
         clr_idx <= (state == CLEAR) ? clr_idx + 7'd1 : 7'd0;
         busy    <= busy_nxt_c;
      end
   end

   logic [6:0] wr_idx;
   assign wr_idx = 7'(cell_y) * 7'd10 + 7'(cell_x);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NCELL; i++) cells[i] <= 2'b00;
      end else if (clr_we_c) begin
         cells[clr_idx] <= 2'b00;
      end else if (wr_en_c) begin
         cells[wr_idx] <= cell_state;
      end
   end

   // Board geometry for the incoming pixel
   logic [8:0]  dx, dy;
   logic        in_board, grid_c;
   logic [6:0]  rd_idx;
   logic [1:0]  cur_state;
   logic [3:0]  row;

   assign dx       = 9'(hcount_in - 11'(X0));
   assign dy       = 9'(vcount_in - 11'(Y0));
   assign in_board = (hcount_in >= 11'(X0)) && (hcount_in <= 11'(X0 + BSIZE - 1)) &&
                     (vcount_in >= 11'(Y0)) && (vcount_in <= 11'(Y0 + BSIZE - 1));
   assign rd_idx    = 7'(dy[8:5]) * 7'd10 + 7'(dx[8:5]);
   assign cur_state = in_board ? cells[rd_idx] : 2'b00;
   assign row       = 4'(dy[4:0] >> 1);

`ifdef DRAW_BOARD_GRID_EN
   assign grid_c = in_board && (dx[4:0] == 5'd0 || dy[4:0] == 5'd0 ||
                                dx == 9'(BSIZE - 1) || dy == 9'(BSIZE - 1));
`else
   assign grid_c = 1'b0;
`endif

   logic [TW-1:0] tim_in, s1_tim, s2_tim;
   logic [4:0]    s1_col, s2_col;
   logic          s1_inb, s2_inb, s1_grid, s2_grid;
   logic [1:0]    s1_state, s2_state;
   logic [11:0]   s1_rgb, s2_rgb;

   assign tim_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};

   // Stage 1 launches the ROM address; stage 2 waits for the ROM line
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom_addr <= '0;
         s1_tim   <= '0;
         s1_col   <= '0;
         s1_inb   <= 1'b0;
         s1_grid  <= 1'b0;
         s1_state <= '0;
         s1_rgb   <= '0;
         s2_tim   <= '0;
         s2_col   <= '0;
         s2_inb   <= 1'b0;
         s2_grid  <= 1'b0;
         s2_state <= '0;
         s2_rgb   <= '0;
      end else begin
         rom_addr <= in_board ? {cur_state, 1'b0, row} : 7'd0;
         s1_tim   <= tim_in;
         s1_col   <= dx[4:0];
         s1_inb   <= in_board;
         s1_grid  <= grid_c;
         s1_state <= cur_state;
         s1_rgb   <= rgb_in;
         s2_tim   <= s1_tim;
         s2_col   <= s1_col;
         s2_inb   <= s1_inb;
         s2_grid  <= s1_grid;
         s2_state <= s1_state;
         s2_rgb   <= s1_rgb;
      end
   end

   logic        pix_c;
   logic [11:0] rgb_nxt_c;

   assign pix_c = ship_line_pixels_in[5'd31 - s2_col];

   always_comb begin
      rgb_nxt_c = s2_rgb;
      if (s2_tim[1] || s2_tim[0]) begin
         rgb_nxt_c = 12'h000;
      end else if (s2_grid) begin
         rgb_nxt_c = GRID_COLOR;
      end else if (s2_inb && pix_c) begin
         case (s2_state)
            2'b01:   rgb_nxt_c = SHIP_COLOR;
            2'b10:   rgb_nxt_c = HIT_COLOR;
            2'b11:   rgb_nxt_c = MISS_COLOR;
            default: rgb_nxt_c = s2_rgb;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} <= '0;
         rgb_out <= '0;
      end else begin
         {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} <= s2_tim;
         rgb_out <= rgb_nxt_c;
      end
   end

endmodule

// File: tb/tb_draw_board.sv
// Self-checking bench for draw_board: directed scenarios plus random traffic
// compared against a per-pixel behavioural model of the board.
module tb_draw_board;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] hcount_in, vcount_in;
   logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
   logic [11:0] rgb_in;
   logic        cell_we;
   logic [3:0]  cell_x, cell_y;
   logic [1:0]  cell_state;
   logic        board_clr;
   logic        busy;
   logic [6:0]  rom_addr;
   logic [31:0] rom_q;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [11:0] rgb_out;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   draw_board dut (
      .clk(clk), .rst(rst),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in),
      .cell_we(cell_we), .cell_x(cell_x), .cell_y(cell_y), .cell_state(cell_state),
      .board_clr(board_clr), .busy(busy), .rom_addr(rom_addr),
      .ship_line_pixels_in(rom_q),
      .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out)
   );

   // Stand-in ship ROM: empty-cell lines are blank, a few fixed lines, the rest hashed
   function automatic logic [31:0] rom_line(input logic [6:0] a);
      if (a[6:5] == 2'b00) return 32'h0;
      if (a == 7'h41)      return 32'hF38001CF;
      if (a == 7'h25)      return 32'h07E00000;
      return (32'(a) * 32'h9E3779B1) ^ 32'hA5C30F96;
   endfunction

   always @(posedge clk) rom_q <= rom_line(rom_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   typedef struct {
      bit          v;
      logic [6:0]  addr;
      logic [11:0] rgb;
      logic [25:0] tim;
      logic        busy;
   } exp_t;

   int   m_cells [100];
   bit   m_clr;
   int   m_idx;
   exp_t hist [3];

   function automatic logic [11:0] color(input int st);
      case (st)
         1: return 12'h888;
         2: return 12'hF00;
         3: return 12'h00F;
         default: return 12'h000;
      endcase
   endfunction

   // One pixel clock: check aged expectations, drive inputs, advance the model
   task automatic step(input int h, input int v, input bit hs, input bit vs,
                       input bit hb, input bit vb, input logic [11:0] rgb,
                       input bit we, input int x, input int y, input int st, input bit clr);
      exp_t e;
      int dx, dy, cs, col, row;
      bit inb, grid;
      logic [31:0] ln;
      @(negedge clk);
      if (hist[0].v) begin
         chk("rom_addr", 32'(rom_addr), 32'(hist[0].addr));
         chk("busy", 32'(busy), 32'(hist[0].busy));
      end
      if (hist[2].v) begin
         chk("rgb_out", 32'(rgb_out), 32'(hist[2].rgb));
         chk("timing", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
             32'(hist[2].tim));
      end
      hcount_in = 11'(h); vcount_in = 11'(v);
      hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb;
      rgb_in = rgb; cell_we = we; cell_x = 4'(x); cell_y = 4'(y);
      cell_state = 2'(st); board_clr = clr;

      dx  = h - 64;
      dy  = v - 48;
      inb = (dx >= 0) && (dx < 320) && (dy >= 0) && (dy < 320);
      cs  = inb ? m_cells[(dy / 32) * 10 + dx / 32] : 0;
      col = inb ? dx % 32 : 0;
      row = inb ? (dy % 32) / 2 : 0;
`ifdef DRAW_BOARD_GRID_EN
      grid = inb && (dx % 32 == 0 || dy % 32 == 0 || dx == 319 || dy == 319);
`else
      grid = 1'b0;
`endif
      e.v    = 1'b1;
      e.addr = inb ? 7'(cs * 32 + row) : 7'd0;
      ln     = rom_line(e.addr);
      e.tim  = {11'(h), 11'(v), hs, vs, hb, vb};
      if (hb || vb)                      e.rgb = 12'h000;
      else if (grid)                     e.rgb = 12'hFFF;
      else if (inb && ln[31 - col])      e.rgb = color(cs);
      else                               e.rgb = rgb;

      if (m_clr) begin
         m_cells[m_idx] = 0;
         m_idx++;
         if (m_idx == 100) m_clr = 1'b0;
      end else if (clr) begin
         m_clr = 1'b1;
         m_idx = 0;
      end else if (we && x < 10 && y < 10) begin
         m_cells[y * 10 + x] = st;
      end
      e.busy  = m_clr;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = e;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 0);
   endtask

   task automatic rand_write();
      step(0, 0, 0, 0, 0, 0, 12'h000, 1, $urandom_range(0, 9), $urandom_range(0, 9),
           $urandom_range(1, 3), 0);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0;
      rgb_in = '0; cell_we = 0; cell_x = '0; cell_y = '0; cell_state = '0; board_clr = 0;
      repeat (n) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_addr", 32'(rom_addr), 32'd0);
      chk("rst_rgb", 32'(rgb_out), 32'd0);
      chk("rst_tim", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'd0);
      for (int i = 0; i < 100; i++) m_cells[i] = 0;
      m_clr = 1'b0;
      m_idx = 0;
      for (int i = 0; i < 3; i++) hist[i].v = 1'b0;
      rst = 1'b0;
   endtask

   // Visit row 0 of every cell; an empty cell there addresses ROM line 0
   task automatic scan_empty(input string tag);
      int nz = 0;
      for (int c = 0; c <= 100; c++) begin
         if (c < 100) step(64 + (c % 10) * 32, 48 + (c / 10) * 32, 0, 0, 0, 0, 12'h0F0, 0, 0, 0, 0, 0);
         else         idle();
         if (c >= 1 && rom_addr != 7'd0) nz++;
      end
      chk(tag, 32'(nz), 32'd0);
   endtask

   initial begin
      logic [11:0] hexp [8];
      int bcnt;
      rst = 1'b1;
      do_reset(5);

      // Empty board renders as pure passthrough
      for (int i = 0; i < 40; i++)
         step(60 + i * 9, 50 + i * 7, i[0], 0, 0, 0, 12'(i * 37), 0, 0, 0, 0, 0);

      // Ship write and render
      step(0, 0, 0, 0, 0, 0, 12'h000, 1, 2, 3, 1, 0);
      step(133, 154, 0, 0, 0, 0, 12'h0AB, 0, 0, 0, 0, 0);
      idle();
      chk("ship_addr", 32'(rom_addr), 32'h25);
      idle(); idle();
      chk("ship_rgb", 32'(rgb_out), 32'h888);

      // Hit cross on cell (0,0), row 1
      step(0, 0, 0, 0, 0, 0, 12'h000, 1, 0, 0, 2, 0);
      hexp = '{12'hF00, 12'hF00, 12'hF00, 12'hF00, 12'h123, 12'h123, 12'hF00, 12'hF00};
      for (int i = 0; i < 11; i++) begin
         step(i < 8 ? 64 + i : 0, 50, 0, 0, 0, 0, 12'h123, 0, 0, 0, 0, 0);
         if (i >= 3) chk("hit_col", 32'(rgb_out), 32'(hexp[i - 3]));
      end

      // Single-cycle blanking/sync pulse inside the board
      step(0, 0, 0, 0, 0, 0, 12'h000, 1, 1, 3, 1, 0);
      for (int i = 0; i < 7; i++) begin
         step(104, 148, i == 1, 0, i == 1, 0, 12'h5A5, 0, 0, 0, 0, 0);
         if (i >= 3) begin
            chk("hblnk_lat", 32'(hblnk_out), 32'(i == 4));
            chk("hsync_lat", 32'(hsync_out), 32'(i == 4));
         end
         if (i == 4) chk("blank_rgb", 32'(rgb_out), 32'h000);
      end

      // Out-of-range writes and off-board pixel
      step(0, 0, 0, 0, 0, 0, 12'h000, 1, 10, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 12'h000, 1, 0, 15, 3, 0);
      step(384, 60, 0, 0, 0, 0, 12'h3C3, 0, 0, 0, 0, 0);
      idle();
      chk("oob_addr", 32'(rom_addr), 32'h0);
      idle(); idle();
      chk("oob_rgb", 32'(rgb_out), 32'h3C3);
      step(64 + 10 * 32 - 1, 48, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 0);
      idle();
      chk("oob_cell_9_0", 32'(rom_addr), 32'h0);

      // Clear with a coincident write, and a re-request while busy
      for (int i = 0; i < 40; i++) rand_write();
      step(0, 0, 0, 0, 0, 0, 12'h000, 1, 5, 5, 1, 1);
      bcnt = 0;
      for (int i = 0; i < 120; i++) begin
         step(64 + $urandom_range(0, 319), 48 + $urandom_range(0, 319), 0, 0, 0, 0,
              12'($urandom), 0, 0, 0, 0, i == 50);
         if (busy) bcnt++;
      end
      chk("clr_busy_len", 32'(bcnt), 32'd100);
      scan_empty("clr_empty");

      // Reset in the middle of a clear
      for (int i = 0; i < 40; i++) rand_write();
      step(0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 1);
      repeat (30) idle();
      do_reset(3);
      scan_empty("rst_empty");

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         int ry;
         ry = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 10);
         step($urandom_range(0, 460), $urandom_range(0, 400),
              $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0,
              12'($urandom), $urandom_range(0, 3) == 0,
              $urandom_range(0, 11), ry, $urandom_range(0, 3),
              $urandom_range(0, 299) == 0);
      end
      repeat (4) idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
